// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, addresses the 16-bit
// instruction RAM, registers each fetched word and hands it to decode over a
// valid/ready handshake. Supports branch redirect, back-pressure stalls and
// HALT detection.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] OP_NOP   = 4'h0,
    parameter logic [2:0] FN_HALT  = 3'h7
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    output logic [7:0]  IMEM_ADDR,
    input  logic [15:0] IMEM_Q,
    output logic [15:0] INSN,
    output logic [7:0]  INSN_PC,
    output logic        INSN_VALID,
    input  logic        INSN_READY,
    input  logic        REDIRECT,
    input  logic [7:0]  REDIRECT_ADDR,
    output logic        HALTED,
    output logic [15:0] FETCH_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    // The PC is always even, including straight out of reset.
    localparam logic [7:0] PC_INIT = {RESET_PC[7:1], 1'b0};

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] insn_q, insn_d;
    logic [7:0]  insn_pc_q, insn_pc_d;
    logic        insn_valid_q, insn_valid_d;
    logic        halted_q, halted_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    logic        slot_free;
    logic        is_halt;
    logic [7:0]  redirect_pc;

    // The output register can take a new word when empty or being drained.
    assign slot_free   = !insn_valid_q || INSN_READY;
    assign is_halt     = (IMEM_Q[15:12] == OP_NOP) && (IMEM_Q[2:0] == FN_HALT);
    assign redirect_pc = {REDIRECT_ADDR[7:1], 1'b0};

    // Next-state logic: redirect beats capture, capture beats stall.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        insn_d        = insn_q;
        insn_pc_d     = insn_pc_q;
        insn_valid_d  = insn_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_IDLE: begin
                if (REDIRECT) begin
                    pc_d = redirect_pc;
                end
                if (START) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (REDIRECT) begin
                    pc_d         = redirect_pc;
                    insn_valid_d = 1'b0;
                end else if (slot_free) begin
                    insn_d       = IMEM_Q;
                    insn_pc_d    = pc_q;
                    insn_valid_d = 1'b1;
                    if (fetch_count_q != 16'hFFFF) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                    if (is_halt) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 8'd2;
                    end
                end
            end

            ST_HALTED: begin
                // Only the handshake still moves: the HALT word drains, nothing refills.
                if (insn_valid_q && INSN_READY) begin
                    insn_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any pending instruction.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            pc_q          <= PC_INIT;
            insn_q        <= 16'h0000;
            insn_pc_q     <= 8'h00;
            insn_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            insn_q        <= insn_d;
            insn_pc_q     <= insn_pc_d;
            insn_valid_q  <= insn_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign IMEM_ADDR   = pc_q;
    assign INSN        = insn_q;
    assign INSN_PC     = insn_pc_q;
    assign INSN_VALID  = insn_valid_q;
    assign HALTED      = halted_q;
    assign FETCH_COUNT = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: two instances (reset PC 00 and FD->FC) share
// the control inputs; each is checked every cycle against a behavioural model,
// with directed literal checks for reset, stall, redirect, halt, wrap and
// asynchronous reset.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        INSN_READY = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [7:0]  REDIRECT_ADDR = 8'h00;

    logic [7:0]  a0, a1, pc0, pc1;
    logic [15:0] q0, q1, i0, i1, c0, c1;
    logic        v0, v1, h0, h1;

    logic [15:0] mem [128];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    assign q0 = mem[a0[7:1]];
    assign q1 = mem[a1[7:1]];

    instr_fetch_unit #(.RESET_PC(8'h00), .OP_NOP(4'h0), .FN_HALT(3'h7)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .IMEM_ADDR(a0), .IMEM_Q(q0),
        .INSN(i0), .INSN_PC(pc0), .INSN_VALID(v0), .INSN_READY(INSN_READY),
        .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
        .HALTED(h0), .FETCH_COUNT(c0)
    );

    instr_fetch_unit #(.RESET_PC(8'hFD), .OP_NOP(4'h0), .FN_HALT(3'h7)) u_wrap (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .IMEM_ADDR(a1), .IMEM_Q(q1),
        .INSN(i1), .INSN_PC(pc1), .INSN_VALID(v1), .INSN_READY(INSN_READY),
        .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
        .HALTED(h1), .FETCH_COUNT(c1)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          running;
        bit          halted;
        bit          valid;
        int          pc;
        int          insn_pc;
        int          count;
        logic [15:0] insn;
    } model_t;

    model_t m0, m1;

    function automatic model_t reset_model(int pc0);
        model_t r;
        r.running = 0; r.halted = 0; r.valid = 0;
        r.pc = pc0; r.insn_pc = 0; r.count = 0; r.insn = 16'h0000;
        return r;
    endfunction

    function automatic model_t step(model_t m, bit start, bit ready, bit redir, int raddr);
        model_t      n = m;
        logic [15:0] word;
        if (m.halted) begin
            if (m.valid && ready) n.valid = 0;
        end else if (!m.running) begin
            if (redir) n.pc = raddr - (raddr % 2);
            if (start) n.running = 1;
        end else if (redir) begin
            n.pc    = raddr - (raddr % 2);
            n.valid = 0;
        end else if (!m.valid || ready) begin
            word      = mem[m.pc / 2];
            n.insn    = word;
            n.insn_pc = m.pc;
            n.valid   = 1;
            if (m.count < 65535) n.count = m.count + 1;
            if (word[15:12] == 4'h0 && word[2:0] == 3'h7) n.halted = 1;
            else n.pc = (m.pc + 2) % 256;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m0 <= reset_model(8'h00);
            m1 <= reset_model(8'hFC);
        end else begin
            m0 <= step(m0, START, INSN_READY, REDIRECT, int'(REDIRECT_ADDR));
            m1 <= step(m1, START, INSN_READY, REDIRECT, int'(REDIRECT_ADDR));
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag, input model_t m,
                             input logic [7:0] addr, input logic [15:0] insn,
                             input logic [7:0] ipc, input logic valid,
                             input logic halted, input logic [15:0] cnt);
        check({tag, ".imem_addr"},   32'(addr),   32'(m.pc));
        check({tag, ".insn_valid"},  32'(valid),  32'(m.valid));
        check({tag, ".halted"},      32'(halted), 32'(m.halted));
        check({tag, ".fetch_count"}, 32'(cnt),    32'(m.count));
        check({tag, ".insn"},        32'(insn),   32'(m.insn));
        check({tag, ".insn_pc"},     32'(ipc),    32'(m.insn_pc));
    endtask

    // Every cycle, compare both instances with the model away from the active edge.
    always @(negedge CLK) begin
        cmp_model("main", m0, a0, i0, pc0, v0, h0, c0);
        cmp_model("wrap", m1, a1, i1, pc1, v1, h1, c1);
    end

    task automatic next();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 16'(16'hA000 + k * 17);
        mem[9]  = 16'h0005;   // 0x12: NOP group, not HALT
        mem[10] = 16'h1007;   // 0x14: HALT function bits, wrong opcode
        mem[11] = 16'h0007;   // 0x16: HALT

        // T1 reset + start
        repeat (3) next();
        check("reset.valid", 32'(v0), 32'h0);
        check("reset.addr",  32'(a0), 32'h00);
        check("reset.wrap_addr", 32'(a1), 32'hFC);
        RESET_N = 1'b1;
        next();
        START = 1'b1;
        next();
        START = 1'b0;
        INSN_READY = 1'b1;
        check("start.no_capture", 32'(v0), 32'h0);
        for (int i = 0; i < 4; i++) begin
            next();
            check("t1.insn_pc",  32'(pc0), 32'(2 * i));
            check("t1.count",    32'(c0),  32'(i + 1));
            check("t1.valid",    32'(v0),  32'h1);
            check("t5.wrap_pc",  32'(pc1), 32'((8'hFC + 2 * i) % 256));
        end
        check("t1.insn06", 32'(i0), 32'h0000A033);

        // T2 stall with INSN_PC=06
        INSN_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            check("t2.insn_pc", 32'(pc0), 32'h06);
            check("t2.addr",    32'(a0),  32'h08);
            check("t2.valid",   32'(v0),  32'h1);
        end
        INSN_READY = 1'b1;
        next();
        check("t2.after_pc", 32'(pc0), 32'h08);
        check("t2.count",    32'(c0),  32'd5);

        // T3 redirect while stalled
        INSN_READY = 1'b0;
        next();
        check("t3.stalled_pc", 32'(pc0), 32'h08);
        REDIRECT = 1'b1;
        REDIRECT_ADDR = 8'h21;
        next();
        check("t3.valid", 32'(v0), 32'h0);
        check("t3.addr",  32'(a0), 32'h20);
        check("t3.count", 32'(c0), 32'd5);
        REDIRECT = 1'b0;
        INSN_READY = 1'b1;
        next();
        check("t3.insn_pc", 32'(pc0), 32'h20);
        check("t3.valid2",  32'(v0),  32'h1);

        // T4 halt at 0x16
        REDIRECT = 1'b1;
        REDIRECT_ADDR = 8'h10;
        next();
        REDIRECT = 1'b0;
        for (int j = 0; j < 4; j++) begin
            next();
            check("t4.insn_pc", 32'(pc0), 32'(8'h10 + 2 * j));
            check("t4.halted",  32'(h0),  32'(j == 3));
        end
        check("t4.insn", 32'(i0), 32'h0007);
        INSN_READY = 1'b0;
        START = 1'b1;
        REDIRECT = 1'b1;
        REDIRECT_ADDR = 8'h40;
        next();
        next();
        check("t4.hold_valid", 32'(v0),  32'h1);
        check("t4.hold_pc",    32'(pc0), 32'h16);
        check("t4.frozen",     32'(a0),  32'h16);
        check("t4.count",      32'(c0),  32'd10);
        START = 1'b0;
        REDIRECT = 1'b0;
        INSN_READY = 1'b1;
        next();
        check("t4.drained", 32'(v0), 32'h0);
        check("t4.still_halted", 32'(h0), 32'h1);
        next();
        check("t4.no_capture", 32'(c0), 32'd10);

        // T6 async reset mid-run
        RESET_N = 1'b0;
        next();
        RESET_N = 1'b1;
        next();
        START = 1'b1;
        next();
        START = 1'b0;
        next();
        next();
        check("t6.pre_valid", 32'(v0), 32'h1);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6.valid", 32'(v0),  32'h0);
        check("t6.insn",  32'(i0),  32'h0);
        check("t6.ipc",   32'(pc0), 32'h0);
        check("t6.count", 32'(c0),  32'h0);
        check("t6.addr",  32'(a0),  32'h00);
        check("t6.waddr", 32'(a1),  32'hFC);
        next();
        RESET_N = 1'b1;
        next();
        check("t6.idle_valid", 32'(v0), 32'h0);
        check("t6.idle_count", 32'(c0), 32'h0);
        REDIRECT = 1'b1;
        REDIRECT_ADDR = 8'h41;
        next();
        REDIRECT = 1'b0;
        check("idle.redirect_addr", 32'(a0), 32'h40);
        check("idle.redirect_valid", 32'(v0), 32'h0);
        START = 1'b1;
        next();
        START = 1'b0;
        next();
        check("idle.insn_pc", 32'(pc0), 32'h40);
        check("idle.insn",    32'(i0),  32'h0000A220);
        check("idle.count",   32'(c0),  32'd1);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
